// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the bounce_gen switch-bounce emulator.
package bounce_gen_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_BOUNCE = 1'b1
   } state_e;

   localparam int unsigned           LFSR_W        = 16;
   // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [LFSR_W-1:0]     LFSR_TAPS     = 16'hB400;
   localparam logic [LFSR_W-1:0]     LFSR_SEED_DEF = 16'hACE1;

   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
      return ^(s & LFSR_TAPS);
   endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Fibonacci LFSR that advances only when i_adv is high.
module bounce_lfsr
   import bounce_gen_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_adv,
   output logic o_bit
);

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (i_adv) lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb(lfsr_q)};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) lfsr_q <= SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign o_bit = lfsr_q[0];

endmodule

// File: rtl/bounce_gen.sv
// Emulates a bouncing mechanical contact following a clean commanded level.
// Optional BOUNCE_RANDOM_EN: pseudo-random toggling from an LFSR instead of toggling every cycle.
module bounce_gen
   import bounce_gen_pkg::*;
#(
   parameter int unsigned N_BOUNCE = 4
`ifdef BOUNCE_RANDOM_EN
   ,
   parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
`endif
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_sig,
   output logic o_sig_bouncy,
   output logic o_busy,
   output logic o_done
);

   localparam int unsigned        CNT_W    = N_BOUNCE + 1;
   localparam logic [CNT_W-1:0]   CNT_TERM = CNT_W'((32'd1 << N_BOUNCE) - 32'd1);

   state_e             state_q, state_d;
   logic               target_q, target_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sig_q, sig_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               toggle_en_c;

`ifdef BOUNCE_RANDOM_EN
   bounce_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rstn  (rstn),
      .i_adv (state_q == ST_BOUNCE),
      .o_bit (toggle_en_c)
   );
`else
   assign toggle_en_c = 1'b1;
`endif

   // A command reversal takes priority over settling at the terminal count
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      sig_d    = sig_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_sig != target_q) begin
               target_d = i_sig;
               cnt_d    = '0;
               state_d  = ST_BOUNCE;
               busy_d   = 1'b1;
            end
         end
         ST_BOUNCE: begin
            if (i_sig != target_q) begin
               target_d = i_sig;
               cnt_d    = '0;
               if (toggle_en_c) sig_d = ~sig_q;
            end else if (cnt_q == CNT_TERM) begin
               sig_d   = target_q;
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (toggle_en_c) sig_d = ~sig_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         target_q <= 1'b0;
         cnt_q    <= '0;
         sig_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         sig_q    <= sig_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign o_sig_bouncy = sig_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen: timing model plus directed scenarios.
module tb_bounce_gen;

   localparam int N_BOUNCE = 4;
   localparam int WIN      = 1 << N_BOUNCE;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic i_sig = 1'b0;
   logic o_sig_bouncy, o_busy, o_done;

   int tests = 0;
   int fails = 0;

   bounce_gen #(.N_BOUNCE(N_BOUNCE)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_sig        (i_sig),
      .o_sig_bouncy (o_sig_bouncy),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: bounce settles exactly WIN edges after the edge that accepted the last change
   bit          m_target = 1'b0;
   bit          m_busy   = 1'b0;
   bit          m_sig    = 1'b0;
   bit          m_done   = 1'b0;
   int          cyc      = 0;
   int          m_start  = 0;
   bit [15:0]   m_lfsr   = 16'hACE1;

   always @(posedge clk or negedge rstn) begin
      bit en;
      if (!rstn) begin
         m_target = 1'b0; m_busy = 1'b0; m_sig = 1'b0; m_done = 1'b0;
         cyc = 0; m_start = 0; m_lfsr = 16'hACE1;
      end else begin
         cyc++;
         m_done = 1'b0;
         en = 1'b1;
`ifdef BOUNCE_RANDOM_EN
         en = m_lfsr[0];
         if (m_busy) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
         if (i_sig != m_target) begin
            m_target = i_sig;
            if (m_busy && en) m_sig = !m_sig;
            m_busy  = 1'b1;
            m_start = cyc;
         end else if (m_busy) begin
            if (cyc - m_start == WIN) begin
               m_sig  = m_target;
               m_busy = 1'b0;
               m_done = 1'b1;
            end else if (en) begin
               m_sig = !m_sig;
            end
         end
      end
   end

   bit chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_sig",  32'(o_sig_bouncy), 32'(m_sig));
         check("model_busy", 32'(o_busy),       32'(m_busy));
         check("model_done", 32'(o_done),       32'(m_done));
      end
   end

   // Downstream debouncer: follows its input only after 16 consecutive differing samples
   logic deb = 1'b0;
   int   deb_stab = 0;
   int   deb_tr = 0;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         deb = 1'b0; deb_stab = 0;
      end else if (o_sig_bouncy == deb) begin
         deb_stab = 0;
      end else if (deb_stab == WIN - 1) begin
         deb = o_sig_bouncy; deb_stab = 0; deb_tr++;
      end else begin
         deb_stab++;
      end
   end

   // Observe n cycles; first_done is the 1-based cycle of the first o_done, -1 if none
   task automatic run_obs(input int n, output int busy_cnt, output int tog, output int done_cnt,
                          output int first_done);
      logic prev;
      prev = o_sig_bouncy;
      busy_cnt = 0; tog = 0; done_cnt = 0; first_done = -1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (o_busy) busy_cnt++;
         if (o_sig_bouncy != prev) tog++;
         prev = o_sig_bouncy;
         if (o_done) begin
            done_cnt++;
            if (first_done < 0) first_done = i + 1;
         end
      end
   endtask

`ifdef BOUNCE_RANDOM_EN
   task automatic rand_run(output logic [31:0] trace, output int tog);
      int b, d, f;
      rstn = 1'b0; i_sig = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      i_sig = 1'b1;
      trace = '0;
      for (int i = 0; i < WIN + 2; i++) begin
         @(negedge clk);
         trace[i] = o_sig_bouncy;
      end
      tog = 0;
      for (int i = 1; i < WIN + 2; i++) if (trace[i] != trace[i-1]) tog++;
      run_obs(4, b, d, f, b);
   endtask
`endif

   initial begin
      int busy_cnt, tog, done_cnt, first_done;
      repeat (3) @(negedge clk);
      check("reset_sig",  32'(o_sig_bouncy), 32'd0);
      check("reset_busy", 32'(o_busy),       32'd0);
      check("reset_done", 32'(o_done),       32'd0);
      rstn = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      // Scenario 1: 0 -> 1
      i_sig = 1'b1;
      run_obs(20, busy_cnt, tog, done_cnt, first_done);
      check("s1_busy_cycles", 32'(busy_cnt), 32'd16);
`ifndef BOUNCE_RANDOM_EN
      check("s1_toggles", 32'(tog), 32'd15);
`endif
      check("s1_done_cnt",   32'(done_cnt),     32'd1);
      check("s1_done_cycle", 32'(first_done),   32'd17);
      check("s1_final_sig",  32'(o_sig_bouncy), 32'd1);

      // Scenario 2: settled 1 -> 0
      i_sig = 1'b0;
      run_obs(20, busy_cnt, tog, done_cnt, first_done);
      check("s2_done_cnt",   32'(done_cnt),     32'd1);
      check("s2_done_cycle", 32'(first_done),   32'd17);
      check("s2_final_sig",  32'(o_sig_bouncy), 32'd0);
      check("s2_final_busy", 32'(o_busy),       32'd0);

      // Scenario 3: reversal at cycle 8 of the bounce restarts the window
      i_sig = 1'b1;
      run_obs(9, busy_cnt, tog, done_cnt, first_done);
      check("s3_no_early_done", 32'(done_cnt), 32'd0);
      i_sig = 1'b0;
      run_obs(24, busy_cnt, tog, done_cnt, first_done);
      check("s3_done_cnt",   32'(done_cnt),     32'd1);
      check("s3_done_cycle", 32'(first_done),   32'd17);
      check("s3_final_sig",  32'(o_sig_bouncy), 32'd0);

      // Scenario 4: asynchronous reset mid-bounce
      i_sig = 1'b1;
      run_obs(5, busy_cnt, tog, done_cnt, first_done);
      check("s4_busy_before_rst", 32'(o_busy), 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("s4_async_sig",  32'(o_sig_bouncy), 32'd0);
      check("s4_async_busy", 32'(o_busy),       32'd0);
      check("s4_async_done", 32'(o_done),       32'd0);
      run_obs(2, busy_cnt, tog, done_cnt, first_done);
      check("s4_no_done_in_rst", 32'(done_cnt), 32'd0);
      rstn = 1'b1;
      run_obs(20, busy_cnt, tog, done_cnt, first_done);
      check("s4_busy_cycles", 32'(busy_cnt),     32'd16);
      check("s4_done_cnt",    32'(done_cnt),     32'd1);
      check("s4_done_cycle",  32'(first_done),   32'd17);
      check("s4_final_sig",   32'(o_sig_bouncy), 32'd1);

      // Scenario 6: debounced loopback must follow i_sig without glitches
      run_obs(20, busy_cnt, tog, done_cnt, first_done);
      check("s6_deb_start", 32'(deb), 32'd1);
      deb_tr = 0;
      i_sig = 1'b0;
      run_obs(40, busy_cnt, tog, done_cnt, first_done);
      check("s6_deb_low", 32'(deb), 32'd0);
      i_sig = 1'b1;
      run_obs(40, busy_cnt, tog, done_cnt, first_done);
      check("s6_deb_high",   32'(deb),    32'd1);
      check("s6_deb_transitions", 32'(deb_tr), 32'd2);

`ifdef BOUNCE_RANDOM_EN
      // Scenario 5: reproducible pseudo-random bounce from reset
      begin
         logic [31:0] tr_a, tr_b;
         int tog_a, tog_b;
         rand_run(tr_a, tog_a);
         rand_run(tr_b, tog_b);
         check("s5_trace_repeat", tr_a, tr_b);
         check("s5_tog_range", 32'((tog_a >= 1) && (tog_a <= 15)), 32'd1);
      end
`endif

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 Parameter N_BOUNCE, default 4: bounce window is 2**N_BOUNCE clock cycles; legal range 1..20.
REQ-002 Parameter LFSR_SEED, default 16'hACE1: nonzero LFSR reset value; zero is illegal.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 i_sig  input  1  clean commanded switch level, synchronous to clk.
REQ-006 o_sig_bouncy  output  1  emulated bouncy switch contact, registered.
REQ-007 o_busy  output  1  high while in BOUNCE.
REQ-008 o_done  output  1  one-cycle pulse on the cycle o_sig_bouncy settles to the target.

Function
REQ-009 States: IDLE and BOUNCE, encoded as a typedef enum.
REQ-010 Register target_q holds the last accepted level of i_sig.
REQ-011 IDLE, i_sig == target_q: no state change; o_sig_bouncy holds target_q.
REQ-012 IDLE, i_sig != target_q: next edge loads target_q <= i_sig and cnt <= 0, enters BOUNCE, and makes o_busy = 1.
REQ-013 BOUNCE, per cycle: cnt increments by 1 and o_sig_bouncy toggles when toggle_en = 1, otherwise holds.
REQ-014 cnt is N_BOUNCE+1 bits wide; its terminal value is 2**N_BOUNCE - 1.
REQ-015 BOUNCE, cnt at terminal value: next edge forces o_sig_bouncy <= target_q, enters IDLE, clears o_busy and asserts o_done for exactly 1 cycle.
REQ-016 BOUNCE, i_sig != target_q (command reverses mid-bounce): target_q <= i_sig and cnt <= 0; state stays BOUNCE; no o_done.
REQ-017 Simultaneous reversal and terminal count: the reversal wins; cnt restarts; no settle and no o_done.
REQ-018 Settled output equals i_sig exactly 2**N_BOUNCE + 1 cycles after the last i_sig change.
REQ-019 In IDLE the LFSR advances only in BOUNCE and holds in IDLE, so bounce patterns are reproducible from reset.

Reset
REQ-020 rstn low asynchronously forces state = IDLE, target_q = 0, cnt = 0, LFSR = LFSR_SEED, o_sig_bouncy = 0, o_busy = 0 and o_done = 0.
REQ-021 Reset asserted mid-BOUNCE aborts the bounce immediately; no o_done is issued.
REQ-022 After release, an i_sig already at 1 is treated as a change and starts a bounce on the first edge.

Configuration
REQ-023 Macro BOUNCE_RANDOM_EN is defined: toggle_en = LFSR bit 0, using a 16-bit Fibonacci LFSR with taps 16,14,13,11 that shifts once per BOUNCE cycle.
REQ-024 Macro BOUNCE_RANDOM_EN is undefined: toggle_en = 1 (a deterministic toggle every BOUNCE cycle); the LFSR and LFSR_SEED are not instantiated.

Structure
REQ-025 Package bounce_gen_pkg holds the state enum, the LFSR width (16), the tap mask constant and the default seed.
REQ-026 Sub-module bounce_lfsr holds the LFSR; it has ports clk, rstn, i_adv and o_bit and is instantiated only under BOUNCE_RANDOM_EN.

Verification
REQ-027 Scenario 1 (macro off, N_BOUNCE=4): reset, then i_sig 0->1 held -> o_busy high for 16 cycles, o_sig_bouncy toggles each cycle, then o_sig_bouncy=1 with a 1-cycle o_done.
REQ-028 Scenario 2: from settled 1, i_sig 1->0 -> after 17 cycles o_sig_bouncy=0, o_done pulses once, and o_busy=0.
REQ-029 Scenario 3: i_sig 0->1, then back to 0 at cycle 8 of the bounce -> cnt restarts, settles to 0 sixteen cycles after the reversal, and exactly one o_done.
REQ-030 Scenario 4: reset asserted at cycle 5 of a bounce -> all outputs 0 asynchronously and no o_done; after release with i_sig=1, a full bounce runs.
REQ-031 Scenario 5 (macro on, seed 16'hACE1): two runs of the same stimulus -> identical o_sig_bouncy traces; the toggle count in the window is between 1 and 15.
REQ-032 Scenario 6: loop o_sig_bouncy into a debouncer configured with N_BOUNCE=4 -> the debounced output matches i_sig, with no glitches.
